// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional-divisor oversample/bit tick generator with runtime
// divisor load and mid-bit resync for the UART TX/RX paths.
module uart_baud_gen #(
   parameter int DIV_W        = 16,
   parameter int FRAC_W       = 4,
   parameter int OVERSAMPLE   = 16,
   parameter int DEFAULT_INT  = 27,
   parameter int DEFAULT_FRAC = 0,
   parameter int MID_ALIGN    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   input  logic              resync,
   output logic              os_tick,
   output logic              bit_tick,
   output logic              cfg_err
);
   localparam int OS_W = $clog2(OVERSAMPLE) > 1 ? $clog2(OVERSAMPLE) : 1;
   localparam int W1   = DIV_W + 1;
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_MID  = (MID_ALIGN != 0 && OVERSAMPLE > 1) ? OS_W'(OVERSAMPLE / 2) : '0;
   logic [DIV_W-1:0]  cnt, cur_int;
   logic [FRAC_W-1:0] acc, cur_frac;
   logic              stretch;
   logic [OS_W-1:0]   os_cnt;
   logic              load_ok, term;
   logic [W1-1:0]     last;
   logic [FRAC_W:0]   acc_sum;
   // Period end computed one bit wider so a max divisor plus stretch cannot wrap.
   always_comb begin
      load_ok = div_load && div_int >= DIV_W'(2);
      last    = {1'b0, cur_int} + W1'(stretch) - W1'(1);
      term    = {1'b0, cnt} == last;
      acc_sum = {1'b0, acc} + {1'b0, cur_frac};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         stretch  <= 1'b0;
         os_cnt   <= '0;
         cur_int  <= DIV_W'(DEFAULT_INT);
         cur_frac <= FRAC_W'(DEFAULT_FRAC);
         os_tick  <= 1'b0;
         bit_tick <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         os_tick  <= 1'b0;
         bit_tick <= 1'b0;
         cfg_err  <= div_load && !load_ok;
         if (load_ok) begin
            cur_int  <= div_int;
            cur_frac <= div_frac;
            cnt      <= '0;
            acc      <= '0;
            stretch  <= 1'b0;
            os_cnt   <= '0;
         end else if (resync) begin
            cnt      <= '0;
            acc      <= '0;
            stretch  <= 1'b0;
            os_cnt   <= OS_MID;
         end else if (en) begin
            if (term) begin
               cnt      <= '0;
               os_tick  <= 1'b1;
               acc      <= acc_sum[FRAC_W-1:0];
               stretch  <= acc_sum[FRAC_W];
               bit_tick <= os_cnt == OS_LAST;
               os_cnt   <= os_cnt == OS_LAST ? '0 : os_cnt + 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: randomized and directed bench for uart_baud_gen against a
// closed-form tick-time model.
module tb_uart_baud_gen;
   localparam int DW = 16, FW = 4, OS = 16;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, div_load = 1'b0, resync = 1'b0;
   logic [DW-1:0] div_int = '0;
   logic [FW-1:0] div_frac = '0;
   logic os_tick, bit_tick, cfg_err;
   int checks = 0, failures = 0;
   uart_baud_gen dut (
      .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
      .div_load(div_load), .resync(resync), .os_tick(os_tick), .bit_tick(bit_tick), .cfg_err(cfg_err)
   );
   always #5 clk = ~clk;
   // Tick k after a phase origin lands k*int + floor((k-1)*frac/2^FW) enabled cycles later.
   longint m_int = 27, m_frac = 0, m_e = 0, m_k = 1, m_os0 = 0;
   bit x_os, x_bit, x_err;
   int cyc = 0, origin = 0, first_os = -1, first_bit = -1, err_cnt = 0;
   int os_t[$], bit_t[$];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask
   function automatic longint target(input longint k);
      return k * m_int + ((k - 1) * m_frac) / (longint'(1) << FW);
   endfunction
   task automatic step(input bit r, input bit e, input bit l, input logic [DW-1:0] di,
                       input logic [FW-1:0] df, input bit rs);
      bit ok;
      rst = r; en = e; div_load = l; div_int = di; div_frac = df; resync = rs;
      ok = l && di >= 2;
      x_os = 0; x_bit = 0; x_err = 0;
      if (r) begin
         m_int = 27; m_frac = 0; m_e = 0; m_k = 1; m_os0 = 0;
         origin = cyc + 1; first_os = -1; first_bit = -1;
      end else begin
         x_err = l && !ok;
         if (ok) begin
            m_int = di; m_frac = df; m_e = 0; m_k = 1; m_os0 = 0;
         end else if (rs) begin
            m_e = 0; m_k = 1; m_os0 = OS / 2;
         end else if (e) begin
            m_e++;
            if (m_e == target(m_k)) begin
               x_os = 1;
               x_bit = ((m_os0 + m_k - 1) % OS) == OS - 1;
               m_k++;
            end
         end
      end
      @(posedge clk); #1;
      cyc++;
      chk("os_tick", os_tick, x_os);
      chk("bit_tick", bit_tick, x_bit);
      chk("cfg_err", cfg_err, x_err);
      if (os_tick === 1'b1) begin
         os_t.push_back(cyc);
         if (first_os < 0) first_os = cyc - origin;
      end
      if (bit_tick === 1'b1) begin
         bit_t.push_back(cyc);
         if (first_bit < 0) first_bit = cyc - origin;
      end
      if (cfg_err === 1'b1) err_cnt++;
      @(negedge clk);
   endtask
   task automatic run_to_os();
      int g = 0;
      do begin
         step(0, 1, 0, 0, 0, 0);
         g++;
      end while (os_tick !== 1'b1 && g < 200);
   endtask
   initial begin
      int n, last_os;
      @(negedge clk);
      repeat (3) step(1, 0, 0, 0, 0, 0);
      repeat (2000) step(0, 1, 0, 0, 0, 0);
      chk("first_os", first_os, 27);
      chk("first_bit", first_bit, 432);
      os_t.delete();
      step(0, 1, 1, 4, 8, 0);
      repeat (200) step(0, 1, 0, 0, 0, 0);
      chk("span32", os_t[32] - os_t[0], 144);
      err_cnt = 0;
      step(0, 1, 1, 1, 3, 0);
      repeat (100) step(0, 1, 0, 0, 0, 0);
      chk("cfg_err_cnt", err_cnt, 1);
      step(0, 1, 1, 4, 0, 0);
      repeat (23) step(0, 1, 0, 0, 0, 0);
      os_t.delete(); bit_t.delete();
      n = cyc;
      step(0, 1, 0, 0, 0, 1);
      repeat (60) step(0, 1, 0, 0, 0, 0);
      chk("rs_first_os", os_t[0] - n, 5);
      chk("rs_bit", bit_t[0], os_t[7]);
      repeat (7) step(0, 1, 0, 0, 0, 0);
      bit_t.delete();
      n = cyc;
      step(0, 1, 1, 6, 0, 1);
      repeat (120) step(0, 1, 0, 0, 0, 0);
      chk("lr_bit", bit_t[0] - n, 97);
      run_to_os();
      last_os = cyc;
      repeat (2) step(0, 1, 0, 0, 0, 0);
      repeat (10) step(0, 0, 0, 0, 0, 0);
      run_to_os();
      chk("en_gap", cyc - last_os, 16);
      repeat (3) step(0, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      repeat (100) step(0, 1, 0, 0, 0, 0);
      chk("rst_first_os", first_os, 27);
      for (int i = 0; i < 4000; i++) begin
         bit r, e, l, rs;
         logic [DW-1:0] di;
         r  = $urandom_range(999) == 0;
         e  = $urandom_range(9) != 0;
         l  = $urandom_range(199) == 0;
         rs = !l && $urandom_range(149) == 0;
         di = $urandom_range(3) == 0 ? DW'($urandom_range(1)) : DW'($urandom_range(40, 2));
         step(r, e, l, di, FW'($urandom), rs);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
